// File: rtl/if_stage_pkg.sv
// Shared constants and types for the instruction-fetch stage.
// Holds the NOP encoding, XLEN, default reset PC and default
// instruction-memory word-address width, plus the IF/ID control encoding.
package if_stage_pkg;

   localparam int          XLEN             = 32;
   localparam logic [31:0] NOP_INST         = 32'h0000_0013; // addi x0, x0, 0
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
   localparam int          DEFAULT_IMEM_AW  = 8;

   // Per-edge action for the IF/ID pipeline register (reset is a separate input).
   typedef enum logic [1:0] {
      IFID_HOLD   = 2'b00,
      IFID_LOAD   = 2'b01,
      IFID_SQUASH = 2'b10
   } ifid_ctrl_e;

endpackage

// File: rtl/if_stage_ifid_reg.sv
// IF/ID pipeline register.
// Load captures a fetched instruction and its PCs; squash replaces the
// instruction with a NOP and clears valid while keeping the PCs; hold keeps all.
module ifid_reg
   import if_stage_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  ifid_ctrl_e       ctrl,
   input  logic [XLEN-1:0]  fetch_inst,
   input  logic [XLEN-1:0]  fetch_pc,
   input  logic [XLEN-1:0]  fetch_pc4,
   output logic [XLEN-1:0]  ifid_inst,
   output logic [XLEN-1:0]  ifid_pc,
   output logic [XLEN-1:0]  ifid_pc4,
   output logic             ifid_valid
);

   // Register update: reset wins, then the control selected by the fetch stage.
   always_ff @(posedge clk) begin
      if (rst) begin
         ifid_inst  <= NOP_INST;
         ifid_pc    <= '0;
         ifid_pc4   <= '0;
         ifid_valid <= 1'b0;
      end else begin
         case (ctrl)
            IFID_LOAD: begin
               ifid_inst  <= fetch_inst;
               ifid_pc    <= fetch_pc;
               ifid_pc4   <= fetch_pc4;
               ifid_valid <= 1'b1;
            end
            IFID_SQUASH: begin
               ifid_inst  <= NOP_INST;
               ifid_valid <= 1'b0;
            end
            default: begin
               ifid_inst  <= ifid_inst;
               ifid_pc    <= ifid_pc;
               ifid_pc4   <= ifid_pc4;
               ifid_valid <= ifid_valid;
            end
         endcase
      end
   end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, instruction-memory addressing and
// IF/ID register control. Fetch latency is one cycle: memory is read
// combinationally from the current PC and the result lands in IF/ID at the
// edge ending that cycle. Edge priority: rst > redirect > stall > advance.
// Optional build macro IF_MISALIGN_CHECK_EN enables the sticky misaligned
// redirect flag; otherwise misalign_err is tied low.
module if_stage
   import if_stage_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
   parameter int          IMEM_AW  = DEFAULT_IMEM_AW
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               stall,
   input  logic               redirect,
   input  logic [31:0]        redirect_pc,
   output logic [IMEM_AW-1:0] imem_addr,
   input  logic [31:0]        imem_data,
   output logic [31:0]        ifid_inst,
   output logic [31:0]        ifid_pc,
   output logic [31:0]        ifid_pc4,
   output logic               ifid_valid,
   output logic               misalign_err
);

   logic [XLEN-1:0] pc;
   logic [XLEN-1:0] pc_plus4;
   logic [XLEN-1:0] redirect_target;
   ifid_ctrl_e      ifid_ctrl;

   // Upper PC bits are not seen by the memory, so addresses wrap at 2^IMEM_AW words.
   assign imem_addr       = pc[IMEM_AW+1:2];
   assign pc_plus4        = pc + 32'd4;
   assign redirect_target = {redirect_pc[31:2], 2'b00};

   // PC register: reset, redirect (overrides stall), hold on stall, else advance.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc <= RESET_PC;
      end else if (redirect) begin
         pc <= redirect_target;
      end else if (!stall) begin
         pc <= pc_plus4;
      end
   end

   // IF/ID action select: a redirect squashes the wrong-path fetch even when stalled.
   always_comb begin
      ifid_ctrl = IFID_HOLD;
      if (redirect) begin
         ifid_ctrl = IFID_SQUASH;
      end else if (!stall) begin
         ifid_ctrl = IFID_LOAD;
      end
   end

   ifid_reg u_ifid_reg (
      .clk        (clk),
      .rst        (rst),
      .ctrl       (ifid_ctrl),
      .fetch_inst (imem_data),
      .fetch_pc   (pc),
      .fetch_pc4  (pc_plus4),
      .ifid_inst  (ifid_inst),
      .ifid_pc    (ifid_pc),
      .ifid_pc4   (ifid_pc4),
      .ifid_valid (ifid_valid)
   );

`ifdef IF_MISALIGN_CHECK_EN
   logic misalign_q;

   // Sticky flag: any redirect with nonzero low target bits sets it until reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         misalign_q <= 1'b0;
      end else if (redirect && (redirect_pc[1:0] != 2'b00)) begin
         misalign_q <= 1'b1;
      end
   end

   assign misalign_err = misalign_q;
`else
   // Low target bits are dropped without comment when the check is not built.
   logic unused_redirect_lsbs;
   assign unused_redirect_lsbs = ^redirect_pc[1:0];
   assign misalign_err         = 1'b0;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios followed by random
// traffic, all compared against a behavioural fetch model after every edge.
module tb_if_stage;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam logic [31:0] NOP      = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic [7:0]  imem_addr;
   logic [31:0] imem_data;
   logic [31:0] ifid_inst;
   logic [31:0] ifid_pc;
   logic [31:0] ifid_pc4;
   logic        ifid_valid;
   logic        misalign_err;

   int vectors     = 0;
   int miscompares = 0;

   // instruction memory contents, read combinationally
   logic [31:0] mem [256];
   assign imem_data = mem[imem_addr];

   // reference model state
   logic [31:0] m_pc;
   logic [31:0] m_inst;
   logic [31:0] m_ipc;
   logic [31:0] m_pc4;
   logic        m_valid;
   logic        m_err;

   if_stage #(.RESET_PC(RESET_PC), .IMEM_AW(8)) dut (
      .clk          (clk),
      .rst          (rst),
      .stall        (stall),
      .redirect     (redirect),
      .redirect_pc  (redirect_pc),
      .imem_addr    (imem_addr),
      .imem_data    (imem_data),
      .ifid_inst    (ifid_inst),
      .ifid_pc      (ifid_pc),
      .ifid_pc4     (ifid_pc4),
      .ifid_valid   (ifid_valid),
      .misalign_err (misalign_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Model of one clock edge, written from the fetch-stage rules.
   task automatic model_edge(input logic r, input logic s, input logic rd, input logic [31:0] rpc);
      if (r) begin
         m_pc = RESET_PC; m_inst = NOP; m_ipc = 0; m_pc4 = 0; m_valid = 0; m_err = 0;
      end else if (rd) begin
         m_inst  = NOP;
         m_valid = 0;
         m_pc    = rpc - (rpc % 4);
`ifdef IF_MISALIGN_CHECK_EN
         if (rpc % 4 != 0) m_err = 1;
`endif
      end else if (!s) begin
         m_inst  = mem[(m_pc / 4) % 256];
         m_ipc   = m_pc;
         m_pc4   = m_pc + 4;
         m_valid = 1;
         m_pc    = m_pc + 4;
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".imem_addr"}, {24'h0, imem_addr}, (m_pc / 4) % 256);
      chk({tag, ".ifid_inst"}, ifid_inst, m_inst);
      chk({tag, ".ifid_pc"}, ifid_pc, m_ipc);
      chk({tag, ".ifid_pc4"}, ifid_pc4, m_pc4);
      chk({tag, ".ifid_valid"}, {31'h0, ifid_valid}, {31'h0, m_valid});
      chk({tag, ".misalign_err"}, {31'h0, misalign_err}, {31'h0, m_err});
   endtask

   // Drive one cycle of inputs away from the edge, then compare just after it.
   task automatic step(input string tag, input logic r, input logic s, input logic rd,
                       input logic [31:0] rpc);
      @(negedge clk);
      rst = r; stall = s; redirect = rd; redirect_pc = rpc;
      @(posedge clk);
      model_edge(r, s, rd, rpc);
      #1;
      check_all(tag);
   endtask

   initial begin
      rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
      m_pc = 0; m_inst = 0; m_ipc = 0; m_pc4 = 0; m_valid = 0; m_err = 0;
      for (int i = 0; i < 256; i++) mem[i] = $urandom;

      // reset for two cycles, then free-running fetch
      step("rst0", 1, 0, 0, 0);
      step("rst1", 1, 0, 0, 0);
      chk("rst_valid", {31'h0, ifid_valid}, 32'h0);
      chk("rst_inst", ifid_inst, NOP);
      step("run0", 0, 0, 0, 0);
      chk("run0_pc_const", ifid_pc, 32'h0);
      step("run1", 0, 0, 0, 0);
      chk("run1_pc_const", ifid_pc, 32'h4);
      step("run2", 0, 0, 0, 0);
      chk("run2_pc_const", ifid_pc, 32'h8);
      chk("run2_addr_const", {24'h0, imem_addr}, 32'd3);

      // stall three cycles at pc = 8
      step("rst2", 1, 0, 0, 0);
      step("adv0", 0, 0, 0, 0);
      step("adv1", 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         step("stall", 0, 1, 0, 0);
         chk("stall_addr_const", {24'h0, imem_addr}, 32'd2);
         chk("stall_pc_const", ifid_pc, 32'h4);
      end

      // redirect beats stall
      step("redir_stall", 0, 1, 1, 32'h40);
      chk("redir_addr_const", {24'h0, imem_addr}, 32'd16);
      chk("redir_inst_const", ifid_inst, NOP);
      step("after_redir", 0, 0, 0, 0);

      // address wrap across 0x3FC -> 0x400
      step("to_3f8", 0, 0, 1, 32'h3F8);
      for (int i = 0; i < 3; i++) step("wrap_run", 0, 0, 0, 0);
      chk("wrap_pc_const", ifid_pc, 32'h400);
      chk("wrap_addr_const", {24'h0, imem_addr}, 32'd1);

      // misaligned redirect, then sticky until reset
      step("misalign", 0, 0, 1, 32'h42);
      step("mis_run0", 0, 0, 0, 0);
      step("mis_run1", 0, 1, 0, 0);

      // redirect to the current pc, then back-to-back redirects
      step("self_redir", 0, 0, 1, m_pc);
      step("chain0", 0, 0, 1, 32'h100);
      step("chain1", 0, 0, 1, 32'h200);
      step("chain2", 0, 1, 1, 32'h31C);
      step("chain_run", 0, 0, 0, 0);

      // 32-bit pc wrap
      step("to_top", 0, 0, 1, 32'hFFFF_FFFC);
      step("top_run0", 0, 0, 0, 0);
      chk("top_pc4_const", ifid_pc4, 32'h0);
      step("top_run1", 0, 0, 0, 0);

      // reset during redirect and stall
      step("rst_redir", 1, 1, 1, 32'h80);
      chk("rst_redir_err", {31'h0, misalign_err}, 32'h0);
      step("post_rst_stall", 0, 1, 0, 0);
      step("post_rst_run", 0, 0, 0, 0);
      chk("post_rst_pc_const", ifid_pc, RESET_PC);

      // random traffic
      for (int i = 0; i < 400; i++) begin
         logic        r, s, rd;
         logic [31:0] rpc;
         r   = ($urandom_range(0, 99) < 2);
         s   = ($urandom_range(0, 99) < 25);
         rd  = ($urandom_range(0, 99) < 15);
         rpc = ($urandom_range(0, 3) == 0) ? $urandom : {20'h0, 12'($urandom_range(0, 4095))};
         step("rand", r, s, rd, rpc);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, PC loaded on reset.
REQ-002 SHALL have parameter IMEM_AW, default 8, instruction-memory word-address width.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port stall  input  1  hold PC and IF/ID register.
REQ-006 SHALL have port redirect  input  1  taken branch/jump; load redirect_pc and squash IF/ID.
REQ-007 SHALL have port redirect_pc  input  32  branch/jump target byte address.
REQ-008 SHALL have port imem_addr  output  IMEM_AW  word address to instruction memory, equals pc[IMEM_AW+1:2].
REQ-009 SHALL have port imem_data  input  32  instruction word, combinational read of imem_addr.
REQ-010 SHALL have port ifid_inst  output  32  registered instruction to decode.
REQ-011 SHALL have port ifid_pc  output  32  registered PC of ifid_inst.
REQ-012 SHALL have port ifid_pc4  output  32  registered ifid_pc+4.
REQ-013 SHALL have port ifid_valid  output  1  ifid_inst is a real fetched instruction.
REQ-014 SHALL have port misalign_err  output  1  sticky misaligned-redirect flag.

Function
REQ-015 imem_addr SHALL be combinational from pc only; fetch latency one cycle (memory read in cycle N, IF/ID updated at edge ending N).
REQ-016 Priority per edge SHALL be rst > redirect > stall > normal advance.
REQ-017 Normal advance: pc<=pc+4; ifid_inst<=imem_data; ifid_pc<=pc; ifid_pc4<=pc+4; ifid_valid<=1.
REQ-018 Stall without redirect: pc and all ifid_* SHALL hold.
REQ-019 Redirect (stall ignored): pc<={redirect_pc[31:2],2'b00}; ifid_inst<=32'h0000_0013 (NOP); ifid_valid<=0; ifid_pc, ifid_pc4 SHALL hold.
REQ-020 pc+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 0); imem_addr SHALL wrap 255 -> 0 as pc crosses 32'h3FC -> 32'h400 (upper pc bits ignored by memory).
REQ-021 Redirect to current pc SHALL still squash IF/ID and refetch.
REQ-022 Redirect asserted in consecutive cycles: last target SHALL win; ifid_valid stays 0 throughout.

Reset
REQ-023 On rst at an edge: pc<=RESET_PC; ifid_inst<=32'h0000_0013; ifid_pc<=0; ifid_pc4<=0; ifid_valid<=0; misalign_err<=0.
REQ-024 rst mid-stall or mid-redirect SHALL override both; first valid fetch is RESET_PC at the first non-stalled edge after rst deasserts.

Configuration
REQ-025 Macro IF_MISALIGN_CHECK_EN: when defined, redirect with redirect_pc[1:0]!=0 SHALL set misalign_err, held until rst; target still aligned per REQ-019.
REQ-026 Without IF_MISALIGN_CHECK_EN, misalign_err SHALL be constant 0 and redirect_pc[1:0] silently ignored; port list unchanged.

Structure
REQ-027 Shared package/header SHALL hold NOP encoding 32'h0000_0013, default RESET_PC, IMEM_AW, XLEN=32.
REQ-028 IF/ID register SHALL be a sub-module ifid_reg (load/hold/squash controls); PC logic remains in if_stage.

Verification
REQ-029 rst 2 cycles, RESET_PC=0, no stall -> imem_addr 0,1,2,3; ifid_pc 0,4,8; ifid_valid 0 then 1.
REQ-030 stall high 3 cycles at pc=8 -> imem_addr stays 2, ifid_pc stays 4, ifid_inst unchanged.
REQ-031 redirect with redirect_pc=32'h40 and stall=1 same cycle -> next pc 32'h40, imem_addr 16, ifid_valid 0, ifid_inst 32'h13.
REQ-032 pc run from 32'h3F8 -> imem_addr 254,255,0; ifid_pc 32'h3F8, 32'h3FC, 32'h400.
REQ-033 redirect_pc=32'h42 -> pc 32'h40; misalign_err 1 with IF_MISALIGN_CHECK_EN until rst, 0 without.
REQ-034 rst during redirect with redirect_pc=32'h80 -> pc RESET_PC, all outputs at REQ-023 values.
